panel_pattern_gen: RTL and testbench
====================================

# panel_pattern_gen

Parametrised test-pattern source for the LED panel driver chain. It replaces the constant all-zero framebuffer feed used during bring-up with selectable, per-column patterns. It serialises one column, MSB-first per 16-bit colour channel, onto `NB_DRIVERS` parallel data lines, one bit per read strobe from the driver controller. It tracks the current column index within a turn and resynchronises it to the rotation position.

## Interface
- `NB_DRIVERS`, 30: number of parallel driver data lines.
- `PIXELS_PER_DRIVER`, 16: pixels per driver per column.
- `NB_COLUMNS`, 128: columns per turn; must be ≥2.
- `clk` in 1: system clock; one clock.
- `nrst` in 1: reset, asynchronous, active-low.
- `mode` in 3: pattern select; sampled only at column start.
- `level` in 16: intensity of lit channels; sampled only at column start.
- `column_ready` in 1: one-cycle pulse; the consumer requests a new column.
- `data_rd` in 1: one-cycle strobe; the consumer has taken the current bit.
- `position_sync` in 1: one-cycle pulse at the rotation index; forces the column index to 0.
- `framebuffer_data` out `NB_DRIVERS`: current bit for each driver.
- `busy` out 1: high while streaming a column.
- `column_done` out 1: one-cycle pulse after the last bit of a column is consumed.
- `column_idx` out `$clog2(NB_COLUMNS)`: index of the column being or last streamed.
- `overrun` out 1: sticky; set when `column_ready` arrives while busy.

## Operation
- The stream order per column is pixel 0..P-1, then channel 0,1,2 within each pixel, then bit 15..0 within each channel. Each column is P×48 beats; the default is 768.
- Counters:
  - `bit_cnt` counts 4 bits, down from 15.
  - `chan_cnt` counts 0..2.
  - `pix_cnt` has `$clog2(P)` bits.
  - All counters wrap in that order.
- FSM states are IDLE and STREAM.
  - IDLE: `framebuffer_data`=0 and `busy`=0. On `column_ready`, latch `mode` and `level`, clear the counters, go to STREAM and set `busy`=1.
  - STREAM: each `data_rd` advances the counters by one beat.
    - On `data_rd` at the last beat (pix=P-1, chan=2, bit=0), pulse `column_done`, increment `column_idx` modulo `NB_COLUMNS`, and return to IDLE.
    - `column_ready` in STREAM is ignored for the stream and sets `overrun`. `overrun` clears only on reset.
- Per-driver bit d, where b = latched `level`[bit_cnt]:
  - mode 0: 0.
  - mode 1 (all on): b.
  - mode 2 (walking pixel): b if pix_cnt == column_idx mod P, else 0.
  - mode 3 (driver colour): b if chan_cnt == d mod 3, else 0.
  - mode 4 (checker): b if pix_cnt[0] XOR column_idx[0], else 0.
  - modes 5–7: treated as mode 0.
- `position_sync` sets `column_idx` to 0 at any time.
  - If it is simultaneous with a column-end increment, sync wins and the index is 0.
  - If it occurs mid-stream, the pattern switches to the new index from the next beat.
- `data_rd` in IDLE is ignored.
- Reset mid-operation immediately returns to IDLE. All outputs go to their reset values and the counters clear.

## Timing
- Reset values: `framebuffer_data`=0, `busy`=0, `column_done`=0, `column_idx`=0, `overrun`=0, state IDLE.
- All outputs are registered.
- First bit (pixel 0, channel 0, bit 15) is valid on `framebuffer_data` the cycle after `column_ready` is sampled. `busy` rises in the same cycle.
- After a `data_rd` in cycle n, the next bit is valid in cycle n+1. Back-to-back `data_rd` every cycle is supported.
- `column_done` is high in the cycle after the final `data_rd`. In that same cycle `busy`=0, `framebuffer_data`=0, and the `column_idx` update becomes visible.
- A `column_ready` in the cycle `column_done` is high is accepted. Minimum column-to-column gap is 1 idle cycle.
- `mode` and `level` changes mid-column have no effect until the next `column_ready`.

## Test plan
- Reset, then mode 1, `level`=16'h8001, `column_ready`, then 768 consecutive `data_rd` -> every driver line repeats 1,0×14,1 per channel. `column_done` pulses exactly once, one cycle after the 768th strobe. `column_idx`=1, `busy`=0.
- Mode 2, `level`=16'hFFFF, `column_idx` advanced to 5 -> lines are 1 only during beats 240..287 (pixel 5). At `column_idx`=21 the lit pixel is also 5 (wrap mod 16).
- Mode 3, `level`=16'hFFFF -> driver 0 is high only in channel 0 beats, driver 1 only in channel 1, driver 2 only in channel 2, driver 3 only in channel 0.
- 128 columns streamed -> `column_idx` wraps 127→0. `position_sync` coincident with the final `data_rd` -> `column_idx`=0, not 1.
- `column_ready` at beat 100 -> `overrun`=1 and stays set, and the stream continues to 768 beats unchanged. `mode` changed mid-column -> the pattern is unchanged until the next column.
- `nrst` low at beat 300 -> asynchronous clear of all outputs, state IDLE. After release, `data_rd` alone produces no change, and a new `column_ready` restarts at pixel 0, bit 15.

Source files
------------

// File: rtl/panel_pattern_gen.sv
// Test-pattern source for the LED panel driver chain: streams one column per request,
// MSB-first per 16-bit channel, onto NB_DRIVERS parallel lines, one beat per data_rd.
module panel_pattern_gen #(
  parameter int NB_DRIVERS        = 30,
  parameter int PIXELS_PER_DRIVER = 16,
  parameter int NB_COLUMNS        = 128
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic [2:0]                    mode,
  input  logic [15:0]                   level,
  input  logic                          column_ready,
  input  logic                          data_rd,
  input  logic                          position_sync,
  output logic [NB_DRIVERS-1:0]         framebuffer_data,
  output logic                          busy,
  output logic                          column_done,
  output logic [$clog2(NB_COLUMNS)-1:0] column_idx,
  output logic                          overrun
);

  localparam int IDX_W = $clog2(NB_COLUMNS);
  localparam int PIX_W = (PIXELS_PER_DRIVER > 1) ? $clog2(PIXELS_PER_DRIVER) : 1;

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_STREAM = 1'b1;

  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIXELS_PER_DRIVER - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NB_COLUMNS - 1);

  logic [0:0]            state_q, state_d;
  logic [3:0]            bit_q, bit_d;
  logic [1:0]            chan_q, chan_d;
  logic [PIX_W-1:0]      pix_q, pix_d;
  logic [2:0]            mode_q, mode_d;
  logic [15:0]           level_q, level_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  done_q, done_d;
  logic                  ovr_q, ovr_d;
  logic [NB_DRIVERS-1:0] fb_q, fb_d;

  always_comb begin
    // NOTE: every next-state signal takes its hold value first, so no path through
    // the decision tree leaves one unassigned and no latch can be inferred.
    state_d = state_q;
    bit_d   = bit_q;
    chan_d  = chan_q;
    pix_d   = pix_q;
    mode_d  = mode_q;
    level_d = level_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    ovr_d   = ovr_q;

    case (state_q)
      S_IDLE: begin
        if (column_ready) begin
          state_d = S_STREAM;
          mode_d  = mode;
          level_d = level;
          bit_d   = 4'd15;
          chan_d  = 2'd0;
          pix_d   = '0;
        end
      end
      default: begin
        if (column_ready) ovr_d = 1'b1;
        // Beat order: bit 15..0, then channel 0..2, then pixel 0..P-1.
        if (data_rd) begin
          if (bit_q != 4'd0) begin
            bit_d = bit_q - 1'b1;
          end else begin
            bit_d = 4'd15;
            if (chan_q != 2'd2) begin
              chan_d = chan_q + 1'b1;
            end else begin
              chan_d = 2'd0;
              if (pix_q != PIX_LAST) begin
                pix_d = pix_q + 1'b1;
              end else begin
                pix_d   = '0;
                state_d = S_IDLE;
                done_d  = 1'b1;
                idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
              end
            end
          end
        end
      end
    endcase

    // Rotation index sync overrides a coincident column-end increment.
    if (position_sync) idx_d = '0;
  end

  // The output bit is computed from next-state values so it is registered yet
  // valid in the same cycle the counters land on the beat.
  logic             lit_bit;
  logic [PIX_W-1:0] walk_pix;

  assign lit_bit  = level_d[bit_d];
  assign walk_pix = PIX_W'(32'(idx_d) % PIXELS_PER_DRIVER);

  always_comb begin
    fb_d = '0;
    if (state_d == S_STREAM) begin
      for (int d = 0; d < NB_DRIVERS; d++) begin
        case (mode_d)
          3'd1:    fb_d[d] = lit_bit;
          3'd2:    fb_d[d] = lit_bit & (pix_d == walk_pix);
          3'd3:    fb_d[d] = lit_bit & (chan_d == 2'(d % 3));
          3'd4:    fb_d[d] = lit_bit & (pix_d[0] ^ idx_d[0]);
          default: fb_d[d] = 1'b0;
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_IDLE;
      bit_q   <= 4'd15;
      chan_q  <= 2'd0;
      pix_q   <= '0;
      mode_q  <= 3'd0;
      level_q <= 16'd0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      fb_q    <= '0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      chan_q  <= chan_d;
      pix_q   <= pix_d;
      mode_q  <= mode_d;
      level_q <= level_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
      fb_q    <= fb_d;
    end
  end

  assign framebuffer_data = fb_q;
  assign busy             = (state_q == S_STREAM);
  assign column_done      = done_q;
  assign column_idx       = idx_q;
  assign overrun          = ovr_q;

endmodule

// File: tb/tb_panel_pattern_gen.sv
// Self-checking bench for panel_pattern_gen: hand-derived vector table, directed corner
// sequences and randomized columns checked against a beat-number arithmetic model.
module tb_panel_pattern_gen;

  localparam int ND = 30;
  localparam logic [ND-1:0] ALL_ON = '1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          nrst;
  logic [2:0]    mode;
  logic [15:0]   level;
  logic [1:0]    ready, rd, sync, busy, done, ovr;
  logic [ND-1:0] fb0, fb1;
  logic [6:0]    idx0;
  logic [1:0]    idx1;

  panel_pattern_gen u_dut (
    .clk(clk), .nrst(nrst), .mode(mode), .level(level),
    .column_ready(ready[0]), .data_rd(rd[0]), .position_sync(sync[0]),
    .framebuffer_data(fb0), .busy(busy[0]), .column_done(done[0]),
    .column_idx(idx0), .overrun(ovr[0])
  );

  // Small instance: short columns and a 4-column turn exercise the index wrap cheaply.
  panel_pattern_gen #(.NB_DRIVERS(ND), .PIXELS_PER_DRIVER(2), .NB_COLUMNS(4)) u_small (
    .clk(clk), .nrst(nrst), .mode(mode), .level(level),
    .column_ready(ready[1]), .data_rd(rd[1]), .position_sync(sync[1]),
    .framebuffer_data(fb1), .busy(busy[1]), .column_done(done[1]),
    .column_idx(idx1), .overrun(ovr[1])
  );

  int assertions = 0;
  int failures   = 0;

  // Reference model state, one slot per instance.
  int          m_idx[2];
  int          m_beat[2];
  int          m_mode[2];
  logic [15:0] m_level[2];
  bit          m_active[2];
  bit          m_ovr[2];

  typedef struct {
    logic [2:0]    md;
    logic [15:0]   lv;
    int            probe;
    int            exp_idx;
    logic [ND-1:0] exp_fb;
  } vec_t;

  vec_t tbl[9];

  function automatic int n_pix(input int w);
    return (w == 0) ? 16 : 2;
  endfunction

  function automatic int n_cols(input int w);
    return (w == 0) ? 128 : 4;
  endfunction

  function automatic logic [ND-1:0] get_fb(input int w);
    return (w == 0) ? fb0 : fb1;
  endfunction

  function automatic int get_idx(input int w);
    return (w == 0) ? int'(idx0) : int'(idx1);
  endfunction

  // Expected bits from the beat number alone: beat k is pixel k/48, channel (k%48)/16,
  // bit 15-(k%16).
  function automatic logic [ND-1:0] model_fb(input int p, input int md, input logic [15:0] lv,
                                             input int idx, input int k);
    logic [ND-1:0] r;
    int   pix, ch, bt;
    logic b;
    pix = k / 48;
    ch  = (k % 48) / 16;
    bt  = 15 - (k % 16);
    b   = lv[bt];
    r   = '0;
    for (int d = 0; d < ND; d++) begin
      case (md)
        1:       r[d] = b;
        2:       r[d] = b && (pix == idx % p);
        3:       r[d] = b && (ch == d % 3);
        4:       r[d] = b && ((pix % 2) != (idx % 2));
        default: r[d] = 1'b0;
      endcase
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One clock with the given pulses on instance w, then model update and full compare.
  task automatic beat_step(input int w, input bit do_rd, input bit do_sync, input bit do_ready);
    bit ended;
    ended    = 1'b0;
    rd[w]    = do_rd;
    sync[w]  = do_sync;
    ready[w] = do_ready;
    step();
    rd    = '0;
    sync  = '0;
    ready = '0;
    if (m_active[w]) begin
      if (do_ready) m_ovr[w] = 1'b1;
      if (do_rd) begin
        if (m_beat[w] == n_pix(w) * 48 - 1) begin
          m_active[w] = 1'b0;
          ended       = 1'b1;
          m_idx[w]    = (m_idx[w] + 1) % n_cols(w);
        end else begin
          m_beat[w]++;
        end
      end
    end else if (do_ready) begin
      m_active[w] = 1'b1;
      m_beat[w]   = 0;
      m_mode[w]   = int'(mode);
      m_level[w]  = level;
    end
    if (do_sync) m_idx[w] = 0;

    check("column_done", done[w], ended);
    check("busy", busy[w], m_active[w]);
    check("overrun", ovr[w], m_ovr[w]);
    check("column_idx", get_idx(w), m_idx[w]);
    check("framebuffer_data", get_fb(w),
          m_active[w] ? model_fb(n_pix(w), m_mode[w], m_level[w], m_idx[w], m_beat[w]) : '0);
  endtask

  task automatic start_col(input int w, input logic [2:0] md, input logic [15:0] lv);
    mode  = md;
    level = lv;
    beat_step(w, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic run_to(input int w, input int k);
    while (m_active[w] && m_beat[w] < k) beat_step(w, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic stream(input int w, input int gap_pct);
    int guard;
    guard = 0;
    while (m_active[w] && guard < 20000) begin
      beat_step(w, ($urandom_range(99) >= gap_pct), 1'b0, 1'b0);
      guard++;
    end
    check("stream_terminates", m_active[w], 1'b0);
  endtask

  task automatic check_cleared(input int w, input string tag);
    check({tag, "_fb"}, get_fb(w), '0);
    check({tag, "_busy"}, busy[w], 1'b0);
    check({tag, "_done"}, done[w], 1'b0);
    check({tag, "_idx"}, get_idx(w), 0);
    check({tag, "_overrun"}, ovr[w], 1'b0);
  endtask

  initial begin
    // Probe beats with hand-derived line images; the column index runs 1..9 in order.
    tbl[0] = '{3'd3, 16'hFFFF, 16,  1, 30'h12492492}; // channel 1: drivers 1,4,7..
    tbl[1] = '{3'd3, 16'hFFFF, 47,  2, 30'h24924924}; // channel 2: drivers 2,5,8..
    tbl[2] = '{3'd4, 16'hFFFF, 0,   3, ALL_ON};       // pixel 0 vs odd index
    tbl[3] = '{3'd4, 16'hFFFF, 48,  4, ALL_ON};       // pixel 1 vs even index
    tbl[4] = '{3'd2, 16'hFFFF, 240, 5, ALL_ON};       // walking pixel 5 lit
    tbl[5] = '{3'd2, 16'hFFFF, 240, 6, '0};           // pixel 5 dark at index 6
    tbl[6] = '{3'd1, 16'h0004, 13,  7, ALL_ON};       // bit 2 of level
    tbl[7] = '{3'd6, 16'hFFFF, 5,   8, '0};           // unused mode is dark
    tbl[8] = '{3'd3, 16'h8000, 48,  9, 30'h09249249}; // pixel 1 channel 0 bit 15

    nrst  = 1'b0;
    mode  = 3'd0;
    level = 16'd0;
    ready = '0;
    rd    = '0;
    sync  = '0;
    for (int w = 0; w < 2; w++) begin
      m_idx[w] = 0; m_beat[w] = 0; m_mode[w] = 0; m_level[w] = '0;
      m_active[w] = 1'b0; m_ovr[w] = 1'b0;
    end

    repeat (2) @(negedge clk);
    check_cleared(0, "reset");
    check_cleared(1, "reset_small");
    nrst = 1'b1;
    step();

    // All-on with level 8001: each channel is 1, fourteen 0s, 1.
    start_col(0, 3'd1, 16'h8001);
    check("a_first_bit", fb0, ALL_ON);
    run_to(0, 1);
    check("a_beat1", fb0, '0);
    run_to(0, 15);
    check("a_beat15", fb0, ALL_ON);
    stream(0, 0);
    check("a_idx_after", idx0, 1);
    check("a_busy_after", busy[0], 1'b0);
    beat_step(0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 9; i++) begin
      start_col(0, tbl[i].md, tbl[i].lv);
      run_to(0, tbl[i].probe);
      check($sformatf("tbl%0d_fb", i), fb0, tbl[i].exp_fb);
      check($sformatf("tbl%0d_idx", i), idx0, tbl[i].exp_idx);
      stream(0, 0);
    end

    // Random patterns and read gaps until the index reaches 21.
    while (m_idx[0] != 21) begin
      start_col(0, 3'($urandom_range(7)), 16'($urandom));
      stream(0, 25);
    end
    start_col(0, 3'd2, 16'hFFFF);
    run_to(0, 239);
    check("walk21_beat239", fb0, '0);
    run_to(0, 240);
    check("walk21_beat240", fb0, ALL_ON);
    stream(0, 0);

    // Overrun at beat 100 plus mid-column mode/level change: stream is unaffected.
    start_col(0, 3'd1, 16'hA5A5);
    run_to(0, 100);
    beat_step(0, 1'b1, 1'b0, 1'b1);
    check("overrun_set", ovr[0], 1'b1);
    mode  = 3'd0;
    level = 16'h0000;
    stream(0, 0);

    // Mid-stream sync with the checker pattern flips parity from the next beat.
    start_col(0, 3'd4, 16'hFFFF);
    run_to(0, 10);
    beat_step(0, 1'b1, 1'b1, 1'b0);
    stream(0, 0);
    check("overrun_sticky", ovr[0], 1'b1);

    // Sync coincident with the final strobe: index ends at 0, not incremented.
    start_col(0, 3'd1, 16'hFFFF);
    run_to(0, 767);
    beat_step(0, 1'b1, 1'b1, 1'b0);
    check("sync_wins_idx", idx0, 0);

    // Asynchronous reset mid-column.
    start_col(0, 3'd1, 16'h00FF);
    beat_step(0, 1'b0, 1'b1, 1'b0);
    run_to(0, 300);
    #2 nrst = 1'b0;
    #1;
    check_cleared(0, "midreset");
    for (int w = 0; w < 2; w++) begin
      m_idx[w] = 0; m_active[w] = 1'b0; m_ovr[w] = 1'b0;
    end
    @(negedge clk);
    nrst = 1'b1;
    for (int i = 0; i < 3; i++) beat_step(0, 1'b1, 1'b0, 1'b0);
    check("rd_alone_idle", busy[0], 1'b0);
    start_col(0, 3'd1, 16'hFFFF);
    check("restart_first_bit", fb0, ALL_ON);
    stream(0, 0);

    // Index wrap on the small instance (last index 3 -> 0).
    for (int c = 0; c < 5; c++) begin
      start_col(1, 3'd2, 16'hFFFF);
      stream(1, 10);
      check($sformatf("small_idx%0d", c), idx1, (c + 1) % 4);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
